// File: rtl/upg_pkg.sv
// Shared types and constants for the UART upgrade loader.
package upg_pkg;

    localparam int unsigned ADDR_W          = 14;
    localparam int unsigned MAX_WORDS       = 16384;
    localparam int unsigned TIMEOUT_CYC_DEF = 1000000;
    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned WORD_W          = 32;
    localparam int unsigned LEN_W           = 16;
    // One extra bit so the word index can reach MAX_WORDS without wrapping.
    localparam int unsigned WIDX_W          = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_DONE   = 3'd3,
        S_ERR    = 3'd4
    } upg_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] adr;
        logic [WORD_W-1:0] dat;
    } upg_wr_t;

    function automatic logic len_too_big(input logic [LEN_W-1:0] len);
        return 32'(len) > MAX_WORDS;
    endfunction

endpackage

// File: rtl/upg_word_pack.sv
// Packs little-endian bytes into 32-bit words; flags the byte that completes a word.
module upg_word_pack
    import upg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_vld,
    input  logic [BYTE_W-1:0] byte_dat,
    output logic [WORD_W-1:0] word_c,
    output logic              word_done_c
);

    // Only the three pending bytes are stored; the fourth arrives live.
    localparam int unsigned SR_W = WORD_W - BYTE_W;

    logic [1:0]      byte_idx;
    logic [SR_W-1:0] sr;

    assign word_c      = {byte_dat, sr};
    assign word_done_c = byte_vld && (byte_idx == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx <= 2'd0;
            sr       <= '0;
        end else if (byte_vld) begin
            byte_idx <= byte_idx + 2'd1;
            sr       <= word_c[WORD_W-1:BYTE_W];
        end
    end

endmodule

// File: rtl/upg_loader.sv
// Frame loader: receives a length-prefixed word stream over UART and issues memory writes.
module upg_loader
    import upg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              upg_clk_i,
    input  logic              upg_rst_i,
    input  logic [7:0]        rx_dat_i,
    input  logic              rx_vld_i,
    output logic              upg_wen_o,
    output logic [13:0]       upg_adr_o,
    output logic [31:0]       upg_dat_o,
    output logic              upg_done_o,
    output logic              err_o
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);

    upg_state_t        state;
    logic [BYTE_W-1:0] len_lo;
    logic [LEN_W-1:0]  len;
    logic [WIDX_W-1:0] word_idx;
    logic [IDLE_W-1:0] idle_cnt;
    upg_wr_t           wr_q;

    logic              pack_vld_c;
    logic              word_done_c;
    logic [WORD_W-1:0] word_c;
    logic [LEN_W-1:0]  len_c;
    logic              last_word_c;
    logic              idle_exp_c;

    assign pack_vld_c  = rx_vld_i && (state == S_DATA);
    assign len_c       = {rx_dat_i, len_lo};
    assign last_word_c = (LEN_W'(word_idx) == (len - LEN_W'(1)));
    assign idle_exp_c  = (idle_cnt == IDLE_W'(TIMEOUT_CYC));

    upg_word_pack u_pack (
        .clk         (upg_clk_i),
        .rst         (upg_rst_i),
        .byte_vld    (pack_vld_c),
        .byte_dat    (rx_dat_i),
        .word_c      (word_c),
        .word_done_c (word_done_c)
    );

    assign upg_adr_o = wr_q.adr;
    assign upg_dat_o = wr_q.dat;

    // Frame FSM with registered write, done and error outputs.
    always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
        if (upg_rst_i) begin
            state      <= S_LEN_LO;
            len_lo     <= '0;
            len        <= '0;
            word_idx   <= '0;
            idle_cnt   <= '0;
            wr_q       <= '0;
            upg_wen_o  <= 1'b0;
            upg_done_o <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            upg_wen_o  <= 1'b0;
            upg_done_o <= (state == S_DONE);
            err_o      <= (state == S_ERR);

            case (state)
                S_LEN_LO: begin
                    idle_cnt <= '0;
                    if (rx_vld_i) begin
                        len_lo <= rx_dat_i;
                        state  <= S_LEN_HI;
                    end
                end

                S_LEN_HI: begin
                    if (rx_vld_i) begin
                        idle_cnt <= '0;
                        len      <= len_c;
                        if (len_c == '0) begin
                            state <= S_DONE;
                        end else if (len_too_big(len_c)) begin
                            state <= S_ERR;
                        end else begin
                            state <= S_DATA;
                        end
                    end else if (idle_exp_c) begin
                        state <= S_ERR;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end

                S_DATA: begin
                    if (rx_vld_i) begin
                        idle_cnt <= '0;
                        if (word_done_c) begin
                            upg_wen_o <= 1'b1;
                            wr_q.adr  <= word_idx[ADDR_W-1:0];
                            wr_q.dat  <= word_c;
                            word_idx  <= word_idx + WIDX_W'(1);
                            if (last_word_c) begin
                                state <= S_DONE;
                            end
                        end
                    end else if (idle_exp_c) begin
                        state <= S_ERR;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end

                S_DONE, S_ERR: begin
                    idle_cnt <= '0;
                end

                default: begin
                    state <= S_ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_upg_loader.sv
// Directed bench for upg_loader using a short timeout so idle expiry is reachable.
module tb_upg_loader;

    logic        upg_clk_i = 1'b0;
    logic        upg_rst_i = 1'b1;
    logic [7:0]  rx_dat_i  = 8'h00;
    logic        rx_vld_i  = 1'b0;
    logic        upg_wen_o;
    logic [13:0] upg_adr_o;
    logic [31:0] upg_dat_o;
    logic        upg_done_o;
    logic        err_o;

    int checks   = 0;
    int failures = 0;

    logic [13:0] wr_adr [$];
    logic [31:0] wr_dat [$];
    int          wide_cnt = 0;
    logic        wen_prev = 1'b0;
    logic [7:0]  burst [16];

    upg_loader #(.TIMEOUT_CYC(50)) dut (
        .upg_clk_i  (upg_clk_i),
        .upg_rst_i  (upg_rst_i),
        .rx_dat_i   (rx_dat_i),
        .rx_vld_i   (rx_vld_i),
        .upg_wen_o  (upg_wen_o),
        .upg_adr_o  (upg_adr_o),
        .upg_dat_o  (upg_dat_o),
        .upg_done_o (upg_done_o),
        .err_o      (err_o)
    );

    always #5 upg_clk_i = ~upg_clk_i;

    // Write log; also counts strobes that stay high for more than one cycle.
    always @(negedge upg_clk_i) begin
        if (upg_wen_o === 1'b1) begin
            wr_adr.push_back(upg_adr_o);
            wr_dat.push_back(upg_dat_o);
            if (wen_prev === 1'b1) wide_cnt++;
        end
        wen_prev = upg_wen_o;
    end

    task automatic clear_log();
        wr_adr.delete();
        wr_dat.delete();
        wide_cnt = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge upg_clk_i);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge upg_clk_i);
        rx_dat_i = b;
        rx_vld_i = 1'b1;
        @(negedge upg_clk_i);
        rx_vld_i = 1'b0;
    endtask

    task automatic send_burst(input int n);
        @(negedge upg_clk_i);
        for (int i = 0; i < n; i++) begin
            rx_dat_i = burst[i];
            rx_vld_i = 1'b1;
            @(negedge upg_clk_i);
        end
        rx_vld_i = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge upg_clk_i);
        upg_rst_i = 1'b1;
        idle(2);
        upg_rst_i = 1'b0;
        clear_log();
    endtask

    task automatic test_reset();
        upg_rst_i = 1'b1;
        idle(3);
        checks++; if (upg_wen_o !== 1'b0) begin failures++; $display("FAIL reset_wen: got %b want 0", upg_wen_o); end
        checks++; if (upg_adr_o !== 14'h0) begin failures++; $display("FAIL reset_adr: got %h want 0", upg_adr_o); end
        checks++; if (upg_dat_o !== 32'h0) begin failures++; $display("FAIL reset_dat: got %h want 0", upg_dat_o); end
        checks++; if (upg_done_o !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", upg_done_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err_o); end
        upg_rst_i = 1'b0;
        idle(2);
        checks++; if ({upg_wen_o, upg_done_o, err_o} !== 3'b000) begin failures++; $display("FAIL reset_release: got %b want 000", {upg_wen_o, upg_done_o, err_o}); end
    endtask

    task automatic test_two_words();
        pulse_reset();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        checks++; if ({upg_wen_o, upg_done_o} !== 2'b10) begin failures++; $display("FAIL two_last_write: wen,done got %b want 10", {upg_wen_o, upg_done_o}); end
        @(negedge upg_clk_i);
        checks++; if ({upg_wen_o, upg_done_o} !== 2'b01) begin failures++; $display("FAIL two_done_edge: wen,done got %b want 01", {upg_wen_o, upg_done_o}); end
        idle(3);
        checks++; if (wr_adr.size() !== 2) begin failures++; $display("FAIL two_count: got %0d want 2", wr_adr.size()); end
        if (wr_adr.size() == 2) begin
            checks++; if (wr_adr[0] !== 14'd0) begin failures++; $display("FAIL two_adr0: got %h want 0", wr_adr[0]); end
            checks++; if (wr_dat[0] !== 32'h12345678) begin failures++; $display("FAIL two_dat0: got %h want 12345678", wr_dat[0]); end
            checks++; if (wr_adr[1] !== 14'd1) begin failures++; $display("FAIL two_adr1: got %h want 1", wr_adr[1]); end
            checks++; if (wr_dat[1] !== 32'hDEADBEEF) begin failures++; $display("FAIL two_dat1: got %h want deadbeef", wr_dat[1]); end
        end
        checks++; if (wide_cnt !== 0) begin failures++; $display("FAIL two_wen_width: got %0d wide pulses want 0", wide_cnt); end
        checks++; if ({upg_done_o, err_o} !== 2'b10) begin failures++; $display("FAIL two_status: done,err got %b want 10", {upg_done_o, err_o}); end
        checks++; if ({upg_adr_o, upg_dat_o} !== {14'd1, 32'hDEADBEEF}) begin failures++; $display("FAIL two_hold: got %h/%h want 1/deadbeef", upg_adr_o, upg_dat_o); end
    endtask

    task automatic test_zero_len();
        pulse_reset();
        idle(80);
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL zero_no_lenlo_timeout: got %b want 0", err_o); end
        send_byte(8'h00); send_byte(8'h00);
        idle(3);
        checks++; if ({upg_done_o, err_o} !== 2'b10) begin failures++; $display("FAIL zero_status: done,err got %b want 10", {upg_done_o, err_o}); end
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        idle(3);
        checks++; if (wr_adr.size() !== 0) begin failures++; $display("FAIL zero_writes: got %0d want 0", wr_adr.size()); end
        checks++; if (upg_done_o !== 1'b1) begin failures++; $display("FAIL zero_done_sticky: got %b want 1", upg_done_o); end
    endtask

    task automatic test_overflow();
        pulse_reset();
        send_byte(8'h01); send_byte(8'h40);
        idle(2);
        checks++; if ({upg_done_o, err_o} !== 2'b01) begin failures++; $display("FAIL ovf_status: done,err got %b want 01", {upg_done_o, err_o}); end
        for (int i = 0; i < 8; i++) send_byte(8'(i * 17));
        idle(3);
        checks++; if (wr_adr.size() !== 0) begin failures++; $display("FAIL ovf_writes: got %0d want 0", wr_adr.size()); end
        checks++; if ({upg_done_o, err_o} !== 2'b01) begin failures++; $display("FAIL ovf_sticky: done,err got %b want 01", {upg_done_o, err_o}); end

        pulse_reset();
        send_byte(8'h00); send_byte(8'h40);
        idle(3);
        checks++; if ({upg_done_o, err_o} !== 2'b00) begin failures++; $display("FAIL max_len_accept: done,err got %b want 00", {upg_done_o, err_o}); end
        send_byte(8'h0D); send_byte(8'hF0); send_byte(8'hFE); send_byte(8'hCA);
        idle(2);
        checks++; if (wr_adr.size() !== 1) begin failures++; $display("FAIL max_len_count: got %0d want 1", wr_adr.size()); end
        if (wr_adr.size() == 1) begin
            checks++; if ({wr_adr[0], wr_dat[0]} !== {14'd0, 32'hCAFEF00D}) begin failures++; $display("FAIL max_len_write: got %h/%h want 0/cafef00d", wr_adr[0], wr_dat[0]); end
        end
        checks++; if (upg_done_o !== 1'b0) begin failures++; $display("FAIL max_len_not_done: got %b want 0", upg_done_o); end
    endtask

    task automatic test_timeout();
        pulse_reset();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA);
        idle(40);
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL timeout_early: got %b want 0", err_o); end
        idle(15);
        checks++; if ({upg_done_o, err_o} !== 2'b01) begin failures++; $display("FAIL timeout_err: done,err got %b want 01", {upg_done_o, err_o}); end
        send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        idle(2);
        checks++; if (wr_adr.size() !== 0) begin failures++; $display("FAIL timeout_writes: got %0d want 0", wr_adr.size()); end
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
        @(negedge upg_clk_i);
        #2 upg_rst_i = 1'b1;
        #1;
        checks++; if ({upg_wen_o, upg_done_o, err_o} !== 3'b000) begin failures++; $display("FAIL midrst_outputs: got %b want 000", {upg_wen_o, upg_done_o, err_o}); end
        @(negedge upg_clk_i);
        upg_rst_i = 1'b0;
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
        idle(3);
        checks++; if (wr_adr.size() !== 1) begin failures++; $display("FAIL midrst_count: got %0d want 1", wr_adr.size()); end
        if (wr_adr.size() == 1) begin
            checks++; if ({wr_adr[0], wr_dat[0]} !== {14'd0, 32'h11223344}) begin failures++; $display("FAIL midrst_write: got %h/%h want 0/11223344", wr_adr[0], wr_dat[0]); end
        end
        checks++; if ({upg_done_o, err_o} !== 2'b10) begin failures++; $display("FAIL midrst_status: done,err got %b want 10", {upg_done_o, err_o}); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_dat [3];
        exp_dat[0] = 32'h03020100;
        exp_dat[1] = 32'h13121110;
        exp_dat[2] = 32'h23222120;
        pulse_reset();
        burst[0] = 8'h03; burst[1] = 8'h00;
        for (int w = 0; w < 3; w++)
            for (int b = 0; b < 4; b++)
                burst[2 + w * 4 + b] = 8'(w * 16 + b);
        send_burst(14);
        idle(3);
        checks++; if (wr_adr.size() !== 3) begin failures++; $display("FAIL b2b_count: got %0d want 3", wr_adr.size()); end
        for (int i = 0; i < 3; i++) begin
            if (wr_adr.size() > i) begin
                checks++; if ({wr_adr[i], wr_dat[i]} !== {14'(i), exp_dat[i]}) begin failures++; $display("FAIL b2b_write%0d: got %h/%h want %h/%h", i, wr_adr[i], wr_dat[i], 14'(i), exp_dat[i]); end
            end
        end
        checks++; if (wide_cnt !== 0) begin failures++; $display("FAIL b2b_wen_width: got %0d wide pulses want 0", wide_cnt); end
        checks++; if ({upg_done_o, err_o} !== 2'b10) begin failures++; $display("FAIL b2b_status: done,err got %b want 10", {upg_done_o, err_o}); end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_zero_len();
        test_overflow();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/upg_loader.md
UPG_LOADER -- requirements
Module: upg_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1000000, the number of idle cycles (100 ms at 10 MHz) allowed between bytes inside a frame.
REQ-002 SHALL have port upg_clk_i  in  1  the single clock (UART programmer clock, 10 MHz).
REQ-003 SHALL have port upg_rst_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port rx_dat_i  in  8  received UART byte.
REQ-005 SHALL have port rx_vld_i  in  1  one-cycle strobe; rx_dat_i is valid in that cycle.
REQ-006 SHALL have port upg_wen_o  out  1  memory write strobe, one cycle wide.
REQ-007 SHALL have port upg_adr_o  out  14  word address of the write.
REQ-008 SHALL have port upg_dat_o  out  32  write data.
REQ-009 SHALL have port upg_done_o  out  1  programming finished; sticky.
REQ-010 SHALL have port err_o  out  1  frame error; sticky.

Function
REQ-011 Frame format SHALL be: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N words of 4 bytes each, least-significant byte first.
REQ-012 The FSM SHALL have the states S_LEN_LO, S_LEN_HI, S_DATA, S_DONE and S_ERR.
REQ-013 In S_LEN_LO a byte SHALL store LEN[7:0] and move the FSM to S_LEN_HI; this state has no timeout.
REQ-014 In S_LEN_HI a byte SHALL complete N; if N==0 the FSM SHALL go to S_DONE; if N>16384 it SHALL go to S_ERR; otherwise it SHALL go to S_DATA.
REQ-015 In S_DATA each byte SHALL shift into the word assembler at byte index 0..3 (a 2-bit counter that wraps).
REQ-016 When byte index 3 is accepted at edge k, upg_wen_o SHALL be 1 for exactly the cycle after edge k, with upg_adr_o = current word index and upg_dat_o = the assembled word.
REQ-017 The word index SHALL start at 0, increment by 1 after each write and never wrap, because N<=16384.
REQ-018 After the write of word N-1 the FSM SHALL enter S_DONE, and upg_done_o SHALL rise at the same edge that deasserts upg_wen_o.
REQ-019 A byte that arrives in the same cycle that upg_wen_o is high SHALL be accepted as byte 0 of the next word and not dropped.
REQ-020 upg_adr_o and upg_dat_o SHALL hold their last values outside write cycles.
REQ-021 The idle counter SHALL clear on every rx_vld_i and increment otherwise while in S_LEN_HI or S_DATA.
REQ-022 When the idle counter reaches TIMEOUT_CYC, the FSM SHALL enter S_ERR.
REQ-023 In S_DONE and S_ERR rx_vld_i SHALL be ignored, and upg_wen_o SHALL stay 0 until reset.
REQ-024 In S_ERR err_o SHALL be 1 and upg_done_o SHALL stay 0, which keeps the memory in programming mode.

Reset
REQ-025 Asserting upg_rst_i, including mid-frame, SHALL immediately clear the FSM to S_LEN_LO and clear the byte index, word index, idle counter and LEN.
REQ-026 During reset upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o and err_o SHALL all be 0.
REQ-027 After reset release the block SHALL accept a new frame starting at the first byte.

Structure
REQ-028 The state encodings, ADDR_W=14, MAX_WORDS=16384 and the default TIMEOUT_CYC SHALL reside in the shared upg_pkg package.
REQ-029 Byte-to-word packing, meaning the 2-bit index, 32-bit shift register and word-complete pulse, SHALL be the single sub-module upg_word_pack.
REQ-030 All outputs SHALL be registered.

Verification
REQ-031 Bytes 02 00 | 78 56 34 12 | EF BE AD DE -> writes adr 0 = 0x12345678 and adr 1 = 0xDEADBEEF, each upg_wen_o one cycle wide, then upg_done_o=1 and err_o=0.
REQ-032 Bytes 00 00 -> upg_done_o=1 with no upg_wen_o pulse.
REQ-033 Bytes 01 40 (N=16385) -> err_o=1, upg_done_o=0, and later bytes produce no writes.
REQ-034 With TIMEOUT_CYC=50, bytes 01 00 AA then 50 idle cycles -> err_o=1 and no write.
REQ-035 Bytes 01 00 11 22, upg_rst_i pulse, then 01 00 44 33 22 11 -> single write adr 0 = 0x11223344, then done.
REQ-036 Back-to-back rx_vld_i every cycle for N=3 -> three writes at adr 0, 1, 2 with no lost byte.
